// File: rtl/seg7_step_display.sv
// -----------------------------------------------------------------------------
// seg7_step_display
//
// Purpose:
//   Time-multiplexed driver for a DIGITS-wide common-anode seven-segment
//   display, plus a single-step button front end. Each digit is held active for
//   REFRESH_CYCLES clocks. The digit contents (hex nibble or raw pattern,
//   optionally blanked) come from shadow registers. The shadows are reloaded
//   only at the end of a full scan, so one scan never mixes two input
//   snapshots.
//   The button is synchronised, optionally debounced and edge detected. Each
//   accepted press produces one step_o pulse, which is meant to be used as a
//   clock enable. step_cnt_o counts those pulses.
//
// Configuration macro:
//   SEG7_BTN_DEBOUNCE_EN - when defined, the accepted button level changes only
//   after the synchronised level has differed from it for DEBOUNCE_CYCLES
//   consecutive clocks. When undefined, the accepted level is simply the
//   synchroniser output and no debounce counter exists.
//
// Parameters:
//   DIGITS          number of multiplexed digits (1..8)
//   REFRESH_CYCLES  clocks each digit is held active (>= 2)
//   DEBOUNCE_CYCLES stable clocks needed to accept a new button level (>= 2)
//
// Ports:
//   CLK100      in   system clock
//   resetn      in   synchronous active-low reset
//   btn_i       in   raw asynchronous step button, active-high
//   hex_i       in   4*DIGITS hex nibbles, digit k = hex_i[4k+3:4k]
//   raw_i       in   7*DIGITS raw {CA..CG} patterns, active-low
//   mode_i      in   per digit: 1 = raw pattern, 0 = hex decode
//   blank_i     in   per digit: 1 = all segments off
//   seg_o       out  registered {CA..CG}, active-low
//   an_o        out  registered anode enables, active-low, one-hot low
//   step_o      out  one-cycle pulse per accepted press
//   step_cnt_o  out  16-bit wrapping count of step_o pulses
// -----------------------------------------------------------------------------
module seg7_step_display #(
    parameter int DIGITS          = 8,
    parameter int REFRESH_CYCLES  = 1000,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                  CLK100,
    input  logic                  resetn,
    input  logic                  btn_i,
    input  logic [4*DIGITS-1:0]   hex_i,
    input  logic [7*DIGITS-1:0]   raw_i,
    input  logic [DIGITS-1:0]     mode_i,
    input  logic [DIGITS-1:0]     blank_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  step_o,
    output logic [15:0]           step_cnt_o
);

    // A single digit still needs a 1-bit index so the scan logic stays uniform.
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    // Active-low {CA..CG} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            4'hF:    pat = 7'b0111000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     refresh_cnt_r;
    logic [IDX_W-1:0]     digit_idx_r;
    logic                 term_s;
    logic                 scan_wrap_s;

    assign term_s      = (refresh_cnt_r == CNT_LAST);
    assign scan_wrap_s = term_s && (digit_idx_r == IDX_LAST);

    // Refresh counter and digit index; the index moves on at each terminal count.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
            digit_idx_r   <= {IDX_W{1'b0}};
        end else if (term_s) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
            if (digit_idx_r == IDX_LAST) begin
                digit_idx_r <= {IDX_W{1'b0}};
            end else begin
                digit_idx_r <= digit_idx_r + IDX_W'(1);
            end
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Shadow snapshot of the display inputs
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0]  hex_sh_r;
    logic [7*DIGITS-1:0]  raw_sh_r;
    logic [DIGITS-1:0]    mode_sh_r;
    logic [DIGITS-1:0]    blank_sh_r;

    // Reload the shadows only as the last digit of a scan finishes.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            hex_sh_r   <= {(4*DIGITS){1'b0}};
            raw_sh_r   <= {(7*DIGITS){1'b0}};
            mode_sh_r  <= {DIGITS{1'b0}};
            blank_sh_r <= {DIGITS{1'b0}};
        end else if (scan_wrap_s) begin
            hex_sh_r   <= hex_i;
            raw_sh_r   <= raw_i;
            mode_sh_r  <= mode_i;
            blank_sh_r <= blank_i;
        end else begin
            hex_sh_r   <= hex_sh_r;
            raw_sh_r   <= raw_sh_r;
            mode_sh_r  <= mode_sh_r;
            blank_sh_r <= blank_sh_r;
        end
    end

    // ------------------------------------------------------------------
    // Segment / anode selection
    // ------------------------------------------------------------------
    logic [6:0]           dig_seg_s [DIGITS];
    logic [6:0]           cur_seg_s;
    logic [DIGITS-1:0]    an_next_s;

    // Per-digit pattern from the shadows: blank wins over raw, raw over hex.
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            dig_seg_s[k] = SEG_OFF;
            if (blank_sh_r[k]) begin
                dig_seg_s[k] = SEG_OFF;
            end else if (mode_sh_r[k]) begin
                dig_seg_s[k] = raw_sh_r[7*k +: 7];
            end else begin
                dig_seg_s[k] = hex_decode(hex_sh_r[4*k +: 4]);
            end
        end
    end

    assign cur_seg_s = dig_seg_s[digit_idx_r];
    assign an_next_s = ~({{(DIGITS-1){1'b0}}, 1'b1} << digit_idx_r);

    // Registered display outputs; both follow the index with one cycle of latency.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            seg_o <= SEG_OFF;
            an_o  <= {DIGITS{1'b1}};
        end else begin
            seg_o <= cur_seg_s;
            an_o  <= an_next_s;
        end
    end

    // ------------------------------------------------------------------
    // Step button front end
    // ------------------------------------------------------------------
    logic                 btn_meta_r;
    logic                 btn_sync_r;
    logic                 btn_lvl_s;
    logic                 btn_lvl_d_r;
    logic                 step_r;
    logic [15:0]          step_cnt_r;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= btn_i;
            btn_sync_r <= btn_meta_r;
        end
    end

`ifdef SEG7_BTN_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0]      db_cnt_r;
    logic                 btn_lvl_r;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
    // samples; any sample equal to the accepted level restarts the count.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            db_cnt_r  <= {DB_W{1'b0}};
            btn_lvl_r <= 1'b0;
        end else if (btn_sync_r == btn_lvl_r) begin
            db_cnt_r  <= {DB_W{1'b0}};
            btn_lvl_r <= btn_lvl_r;
        end else if (db_cnt_r == DB_LAST) begin
            db_cnt_r  <= {DB_W{1'b0}};
            btn_lvl_r <= btn_sync_r;
        end else begin
            db_cnt_r  <= db_cnt_r + DB_W'(1);
            btn_lvl_r <= btn_lvl_r;
        end
    end

    assign btn_lvl_s = btn_lvl_r;
`else
    assign btn_lvl_s = btn_sync_r;
`endif

    // Rising-edge detect of the accepted level. A held button cannot repeat,
    // and reset clears the history so a press held through reset yields one step.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            btn_lvl_d_r <= 1'b0;
            step_r      <= 1'b0;
        end else begin
            btn_lvl_d_r <= btn_lvl_s;
            step_r      <= btn_lvl_s & ~btn_lvl_d_r;
        end
    end

    // Step counter updates the cycle after each pulse and wraps naturally.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            step_cnt_r <= 16'h0000;
        end else if (step_r) begin
            step_cnt_r <= step_cnt_r + 16'h0001;
        end else begin
            step_cnt_r <= step_cnt_r;
        end
    end

    assign step_o     = step_r;
    assign step_cnt_o = step_cnt_r;

endmodule

// File: tb/tb_seg7_step_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_step_display
//
// Self-checking bench for seg7_step_display with DIGITS=4, REFRESH_CYCLES=4,
// DEBOUNCE_CYCLES=8. It checks the reset state, the scan order and the
// snapshot behaviour of the display against a small scan model, the
// raw/blank/hex priority, the button glitch response, reset mid-press, and
// the 16-bit step counter wrap.
// -----------------------------------------------------------------------------
module tb_seg7_step_display;

    localparam int DIG  = 4;
    localparam int REF  = 4;
    localparam int DEB  = 8;
    localparam int SCAN = DIG * REF;

    logic          CLK100;
    logic          resetn;
    logic          btn_i;
    logic [15:0]   hex_i;
    logic [27:0]   raw_i;
    logic [3:0]    mode_i;
    logic [3:0]    blank_i;
    logic [6:0]    seg_o;
    logic [3:0]    an_o;
    logic          step_o;
    logic [15:0]   step_cnt_o;

    seg7_step_display #(
        .DIGITS          (DIG),
        .REFRESH_CYCLES  (REF),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK100     (CLK100),
        .resetn     (resetn),
        .btn_i      (btn_i),
        .hex_i      (hex_i),
        .raw_i      (raw_i),
        .mode_i     (mode_i),
        .blank_i    (blank_i),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .step_o     (step_o),
        .step_cnt_o (step_cnt_o)
    );

    initial CLK100 = 1'b0;
    always #5 CLK100 = ~CLK100;

    int n_cmp = 0;
    int n_mis = 0;

    // Scan model state: clocks since reset release, and the model shadows.
    int          cyc;
    logic [15:0] m_hex;
    logic [27:0] m_raw;
    logic [3:0]  m_mode;
    logic [3:0]  m_blank;

    // Step pulse monitor.
    int   pulses   = 0;
    int   wide_cnt = 0;
    logic step_prev = 1'b0;

    always @(negedge CLK100) begin
        if (step_o) pulses++;
        if (step_o && step_prev) wide_cnt++;
        step_prev = step_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0: p = 7'b0000001;  4'h1: p = 7'b1001111;
            4'h2: p = 7'b0010010;  4'h3: p = 7'b0000110;
            4'h4: p = 7'b1001100;  4'h5: p = 7'b0100100;
            4'h6: p = 7'b0100000;  4'h7: p = 7'b0001111;
            4'h8: p = 7'b0000000;  4'h9: p = 7'b0000100;
            4'hA: p = 7'b0001000;  4'hB: p = 7'b1100000;
            4'hC: p = 7'b0110001;  4'hD: p = 7'b1000010;
            4'hE: p = 7'b0110000;  4'hF: p = 7'b0111000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] model_seg(input int k);
        if (m_blank[k])     return 7'b1111111;
        else if (m_mode[k]) return m_raw[7*k +: 7];
        else                return hex7(m_hex[4*k +: 4]);
    endfunction

    // One clock of the scan: predict an_o/seg_o for this edge, update model
    // shadows on the end-of-scan edge, then compare on the falling edge.
    task automatic scan_check(input string tag);
        int         k;
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        one     = 4'b0001;
        k       = (cyc / REF) % DIG;
        exp_an  = ~(one << k);
        exp_seg = model_seg(k);
        if ((cyc % SCAN) == SCAN - 1) begin
            m_hex   = hex_i;
            m_raw   = raw_i;
            m_mode  = mode_i;
            m_blank = blank_i;
        end
        @(posedge CLK100);
        cyc++;
        @(negedge CLK100);
        check_eq({tag, "_an"},  {28'd0, an_o},  {28'd0, exp_an});
        check_eq({tag, "_seg"}, {25'd0, seg_o}, {25'd0, exp_seg});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK100);
    endtask

    int p0;
    int exp_glitch;

    initial begin
        resetn  = 1'b0;
        btn_i   = 1'b0;
        hex_i   = 16'h3210;
        raw_i   = 28'd0;
        mode_i  = 4'b0000;
        blank_i = 4'b0000;
        cyc     = 0;
        m_hex   = 16'h0000;
        m_raw   = 28'd0;
        m_mode  = 4'b0000;
        m_blank = 4'b0000;

        // Reset state
        wait_cycles(3);
        check_eq("rst_seg",  {25'd0, seg_o},      32'h0000007F);
        check_eq("rst_an",   {28'd0, an_o},       32'h0000000F);
        check_eq("rst_step", {31'd0, step_o},     32'h00000000);
        check_eq("rst_cnt",  {16'd0, step_cnt_o}, 32'h00000000);

        // First scan shows zero shadows, second shows 3,2,1,0 on digits 3..0
        resetn = 1'b1;
        for (int i = 0; i < 2 * SCAN; i++) scan_check("scan_hex");
        // Hand-computed spot check: last digit of the second scan is hex 3
        check_eq("scan2_d3", {25'd0, seg_o}, {25'd0, 7'b0000110});

        // Raw on digit 1, blank on digit 3; applied at the next wrap
        mode_i      = 4'b0010;
        raw_i       = 28'd0;
        raw_i[13:7] = 7'b1010101;
        blank_i     = 4'b1000;
        for (int i = 0; i < 2 * SCAN; i++) scan_check("scan_mix");
        check_eq("mix_d3_blank", {25'd0, seg_o}, {25'd0, 7'b1111111});

        // Hex change in the middle of a scan stays hidden until the wrap
        for (int i = 0; i < SCAN / 2; i++) scan_check("scan_pre");
        hex_i = 16'hCDEF;
        for (int i = 0; i < SCAN / 2 + SCAN; i++) scan_check("scan_mid");
        check_eq("mid_d3_blank", {25'd0, seg_o}, {25'd0, 7'b1111111});

        // Button glitch: 1 x5, 0 x1, 1 x20
`ifdef SEG7_BTN_DEBOUNCE_EN
        exp_glitch = 1;
`else
        exp_glitch = 2;
`endif
        p0 = pulses;
        btn_i = 1'b1; wait_cycles(5);
        btn_i = 1'b0; wait_cycles(1);
        btn_i = 1'b1; wait_cycles(20);
        btn_i = 1'b0; wait_cycles(30);
        check_eq("glitch_steps", pulses - p0, exp_glitch);
        check_eq("glitch_cnt",   {16'd0, step_cnt_o}, exp_glitch);

        // Reset while the button is held, then release with it still held
        btn_i = 1'b1; wait_cycles(1);
        resetn = 1'b0;
        p0 = pulses;
        wait_cycles(6);
        check_eq("rstpress_nostep", pulses - p0, 0);
        check_eq("rstpress_cnt0",   {16'd0, step_cnt_o}, 32'h0);
        resetn = 1'b1;
        wait_cycles(25);
        check_eq("rstpress_one", pulses - p0, 1);
        check_eq("rstpress_cnt", {16'd0, step_cnt_o}, 32'h1);
        btn_i = 1'b0;
        wait_cycles(25);
        check_eq("width_one", wide_cnt, 0);

`ifndef SEG7_BTN_DEBOUNCE_EN
        // Count up from 1 to 0xFFFF, then one more press wraps to 0
        for (int i = 0; i < 65534; i++) begin
            btn_i = 1'b1; wait_cycles(1);
            btn_i = 1'b0; wait_cycles(1);
        end
        wait_cycles(5);
        check_eq("cnt_ffff", {16'd0, step_cnt_o}, 32'h0000FFFF);
        btn_i = 1'b1; wait_cycles(1);
        btn_i = 1'b0; wait_cycles(6);
        check_eq("cnt_wrap", {16'd0, step_cnt_o}, 32'h00000000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/seg7_step_display.md
SEG7_STEP_DISPLAY -- requirements
Module: seg7_step_display

Interface
REQ-001 The block SHALL have parameter DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter REFRESH_CYCLES, default 1000, CLK100 cycles each digit is held active (legal >= 2).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 65536, CLK100 cycles a synchronised button level must be stable to be accepted (legal >= 2).
REQ-004 The block SHALL have port CLK100  input  1  system clock.
REQ-005 The block SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port btn_i  input  1  raw asynchronous step button, active-high.
REQ-007 The block SHALL have port hex_i  input  4*DIGITS  hex nibbles; digit k = hex_i[4k+3:4k].
REQ-008 The block SHALL have port raw_i  input  7*DIGITS  raw pattern {CA..CG}, active-low; digit k = raw_i[7k+6:7k].
REQ-009 The block SHALL have port mode_i  input  DIGITS  per digit: 1 = raw_i, 0 = hex decode.
REQ-010 The block SHALL have port blank_i  input  DIGITS  per digit: 1 = all segments off.
REQ-011 The block SHALL have port seg_o  output  7  {CA..CG}, active-low.
REQ-012 The block SHALL have port an_o  output  DIGITS  anode enables, active-low.
REQ-013 The block SHALL have port step_o  output  1  one-cycle pulse per accepted press; used as a clock enable, never as a clock.
REQ-014 The block SHALL have port step_cnt_o  output  16  count of step_o pulses, wraps 0xFFFF -> 0x0000.

Function
REQ-015 Refresh counter SHALL count 0..REFRESH_CYCLES-1; at terminal count it SHALL return to 0 and digit index SHALL advance, DIGITS-1 wrapping to 0.
REQ-016 an_o SHALL be registered, exactly one bit low (bit = digit index), 1-cycle latency from index change.
REQ-017 seg_o SHALL be registered in the same cycle as an_o, from the shadow copy of the current digit: blank -> 7'b1111111; else raw -> raw pattern; else hex decode.
REQ-018 Hex decode SHALL use: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-019 Shadow registers (hex_i, raw_i, mode_i, blank_i) SHALL capture all inputs only in the cycle where the refresh counter is at terminal count and index = DIGITS-1, so one scan never mixes two input snapshots.
REQ-020 btn_i SHALL pass a two-flop synchroniser before any other use.
REQ-021 step_o SHALL pulse exactly one cycle on each 0->1 transition of the accepted button level; a held button SHALL NOT repeat.
REQ-022 step_cnt_o SHALL increment in the cycle after step_o is high.
REQ-023 DIGITS = 1 SHALL hold an_o[0] low permanently while refreshing seg_o each scan.

Reset
REQ-024 While resetn = 0 at a CLK100 edge: seg_o = 7'b1111111, an_o all 1, step_o = 0, step_cnt_o = 0, index = 0, refresh counter = 0, shadows = 0, accepted button level = 0, debounce counter = 0.
REQ-025 The first cycle after release SHALL drive an_o[0] low with seg_o = 7'b0000001 (shadow zero, hex "0") until the first shadow capture.
REQ-026 Reset mid-press SHALL abort any pending step; a button held through release SHALL yield exactly one step_o once acceptance completes.

Configuration
REQ-027 Macro SEG7_BTN_DEBOUNCE_EN defined: accepted level SHALL change only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level SHALL clear the counter.
REQ-028 SEG7_BTN_DEBOUNCE_EN undefined: DEBOUNCE_CYCLES SHALL be ignored, no debounce counter exists, accepted level = synchroniser output.

Verification (DIGITS=4, REFRESH_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-029 Reset release, hex_i=16'h3210 -> an_o 1110 for 4 cycles then 1101,1011,0111,1110; first scan all seg_o=0000001, second scan 0000001,1001111,0010010,0000110.
REQ-030 mode_i=4'b0010, raw_i digit1=7'b1010101, blank_i=4'b1000 -> digit1 shows 1010101, digit3 shows 1111111.
REQ-031 hex_i changed mid-scan -> displayed values change only at the next index 3->0 wrap.
REQ-032 With SEG7_BTN_DEBOUNCE_EN: btn_i 1 for 5 cycles, 0 for 1, then 1 for 20 -> exactly one step_o, about 10 cycles after the final rise, step_cnt_o 0->1.
REQ-033 step_cnt_o forced to 0xFFFF by 65535 presses, one more press -> 0x0000.
REQ-034 resetn low while btn_i held high, then released -> no step_o during reset, exactly one step_o afterwards.
